// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: baud divider, 5..9 data bits, optional parity,
// 1 or 2 stop bits, valid/ready word capture. TX, tx_busy and tx_done are registered.
`timescale 1ns/1ps
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clc,
    input  logic                 res,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              ODD_FLIP  = (PARITY == 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_tx_param: CLKS_PER_BIT must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_reg,  state_next;
    logic [BAUD_W-1:0]      baud_reg,   baud_next;
    logic [BIT_W-1:0]       bit_reg,    bit_next;
    logic [DATA_BITS-1:0]   shift_reg,  shift_next;
    logic                   parity_reg, parity_next;
    logic                   tx_reg,     tx_next;
    logic                   busy_reg,   busy_next;
    logic                   done_reg,   done_next;
    logic                   bit_end;

    assign bit_end  = (baud_reg == BAUD_LAST);
    assign tx_ready = (state_reg == S_IDLE);

    // tx_next is the line level of the state being entered, so TX changes on
    // the same edge as the state register.
    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        tx_next     = tx_reg;
        done_next   = 1'b0;

        if (state_reg != S_IDLE) begin
            baud_next = bit_end ? '0 : baud_reg + 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                tx_next = 1'b1;
                if (tx_valid) begin
                    state_next  = S_START;
                    tx_next     = 1'b0;
                    baud_next   = '0;
                    bit_next    = '0;
                    shift_next  = tx_data;
                    parity_next = (^tx_data) ^ ODD_FLIP;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                    tx_next    = shift_reg[0];
                    bit_next   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_reg == DATA_LAST) begin
                        bit_next = '0;
                        if (PARITY != 0) begin
                            state_next = S_PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = S_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                    tx_next    = 1'b1;
                    bit_next   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_reg == STOP_LAST) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clc) begin
        if (!res) begin
            state_reg  <= S_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign TX      = tx_reg;
    assign tx_busy = busy_reg;
    assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: six parameter sets run in parallel, each
// compared cycle by cycle against a frame built from the bit-level frame rules.
`timescale 1ns/1ps
module tb_uart_tx_param;

    localparam int NCFG = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit cfg_done [NCFG];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit all_done();
        bit d = 1'b1;
        for (int i = 0; i < NCFG; i++) d &= cfg_done[i];
        return d;
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int CPB = (gi == 4) ? 2 : (gi == 5) ? 5 : 4;
        localparam int DB  = (gi == 3) ? 7 : (gi == 4) ? 5 : (gi == 5) ? 9 : 8;
        localparam int PAR = (gi == 1 || gi == 4) ? 2 : (gi == 2 || gi == 5) ? 1 : 0;
        localparam int SB  = (gi == 3 || gi == 5) ? 2 : 1;
        localparam int LEN = CPB * (1 + DB + ((PAR != 0) ? 1 : 0) + SB);

        logic          res_i;
        logic [DB-1:0] data_i;
        logic          valid_i;
        logic          ready_o, tx_o, busy_o, done_o;

        uart_tx_param #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DB),
            .PARITY      (PAR),
            .STOP_BITS   (SB)
        ) dut (
            .clc     (clk),
            .res     (res_i),
            .tx_data (data_i),
            .tx_valid(valid_i),
            .tx_ready(ready_o),
            .TX      (tx_o),
            .tx_busy (busy_o),
            .tx_done (done_o)
        );

        // Reference: list of frame bits, each stretched to CPB cycles.
        function automatic logic [127:0] ref_wave(input logic [8:0] w);
            bit q[$];
            int ones = 0;
            logic [127:0] wave = '0;
            q.push_back(1'b0);
            for (int i = 0; i < DB; i++) begin
                q.push_back(w[i]);
                ones += int'(w[i]);
            end
            if (PAR == 2) q.push_back(ones % 2 == 1);
            else if (PAR == 1) q.push_back(ones % 2 == 0);
            for (int i = 0; i < SB; i++) q.push_back(1'b1);
            for (int k = 0; k < q.size() * CPB; k++) wave[k] = q[k / CPB];
            return wave;
        endfunction

        function automatic string tg(input string s);
            return $sformatf("cfg%0d %s", gi, s);
        endfunction

        task automatic idle_check(input int n);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                check(tg("idle {tx,busy,done,ready}"), {124'b0, tx_o, busy_o, done_o, ready_o}, 128'b1001);
            end
        endtask

        // Accept w on the next posedge, then observe the whole frame and the done cycle.
        task automatic do_frame(input logic [8:0] w, input bit load, input bit hold,
                                input logic [8:0] nxt, input bit poke);
            logic [127:0] obs_w = '0;
            int busy_n = 0, rdy_n = 0, done_n = 0;
            if (load) begin
                @(negedge clk);
                valid_i = 1'b1;
                data_i  = w[DB-1:0];
            end
            @(posedge clk);
            #1;
            data_i  = hold ? nxt[DB-1:0] : DB'($urandom);
            valid_i = hold;
            for (int k = 0; k < LEN; k++) begin
                @(negedge clk);
                obs_w[k] = tx_o;
                busy_n += int'(busy_o);
                rdy_n  += int'(ready_o);
                done_n += int'(done_o);
                if (poke && k == LEN / 2) begin
                    valid_i = 1'b1;
                    data_i  = DB'($urandom);
                end else if (poke && k == LEN / 2 + 1) begin
                    valid_i = 1'b0;
                end
            end
            check(tg("wave"), obs_w, ref_wave(w));
            check(tg("busy_cycles"), 128'(busy_n), 128'(LEN));
            check(tg("ready_in_frame"), 128'(rdy_n), 128'd0);
            check(tg("done_in_frame"), 128'(done_n), 128'd0);
            @(negedge clk);
            check(tg("end {done,busy,tx,ready}"), {124'b0, done_o, busy_o, tx_o, ready_o}, 128'b1011);
            $display("cfg%0d frame word=%0h len=%0d", gi, w[DB-1:0], LEN);
        endtask

        initial begin
            logic [8:0] w;
            cfg_done[gi] = 1'b0;
            res_i   = 1'b0;
            valid_i = 1'b1;
            data_i  = '1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check(tg("reset {tx,busy,done,ready}"), {124'b0, tx_o, busy_o, done_o, ready_o}, 128'b1001);
            res_i   = 1'b1;
            valid_i = 1'b0;
            idle_check(2);

            do_frame(9'h0A5, 1'b1, 1'b0, 9'h0, 1'b0);
            idle_check(2);
            do_frame(9'h001, 1'b1, 1'b0, 9'h0, 1'b0);
            idle_check(1);
            do_frame(9'h07F, 1'b1, 1'b0, 9'h0, 1'b0);
            idle_check(1);

            // Back-to-back with valid held; second frame must start right after the done cycle.
            do_frame(9'h011, 1'b1, 1'b1, 9'h022, 1'b0);
            do_frame(9'h022, 1'b0, 1'b0, 9'h0, 1'b0);
            idle_check(2);

            for (int r = 0; r < 6; r++) begin
                w = 9'($urandom);
                do_frame(w, 1'b1, 1'b0, 9'h0, 1'b0);
                idle_check(1);
            end

            // Valid pulsed while busy must leave no trace.
            w = 9'($urandom);
            do_frame(w, 1'b1, 1'b0, 9'h0, 1'b1);
            idle_check(LEN / 2);

            // Reset during data bit 3 aborts the frame without a done pulse.
            w = 9'($urandom);
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = w[DB-1:0];
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            repeat (4 * CPB + 1) @(posedge clk);
            #1;
            check(tg("data_bit3"), {127'b0, tx_o}, {127'b0, w[3]});
            res_i = 1'b0;
            @(posedge clk);
            #1;
            res_i = 1'b1;
            @(negedge clk);
            check(tg("abort {tx,busy,done,ready}"), {124'b0, tx_o, busy_o, done_o, ready_o}, 128'b1001);
            idle_check(3 * CPB);

            w = 9'($urandom);
            do_frame(w, 1'b1, 1'b0, 9'h0, 1'b0);
            idle_check(1);
            cfg_done[gi] = 1'b1;
        end
    end

    initial begin
        int cyc = 0;
        while (!all_done() && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        check("all_configs_finished", {127'b0, all_done()}, 128'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
